// File: rtl/vx_tex_lsu_cache_arb_pkg.sv
// Shared types and tag helpers for the texture/LSU dcache arbiter.
package vx_tex_arb_pkg;

   typedef enum logic {
      SRC_LSU = 1'b0,
      SRC_TEX = 1'b1
   } src_e;

   localparam int NUM_SRC   = 2;
   localparam int TAG_MAX_W = 64;

   // Insert the source bit at position idx, shifting the upper tag bits up by one.
   function automatic logic [TAG_MAX_W-1:0] tag_insert(input logic [TAG_MAX_W-1:0] tag,
                                                       input logic                 sel,
                                                       input int                   idx);
      logic [TAG_MAX_W-1:0] low_mask;
      low_mask = (TAG_MAX_W'(1) << idx) - TAG_MAX_W'(1);
      return ((tag & ~low_mask) << 1) | (TAG_MAX_W'(sel) << idx) | (tag & low_mask);
   endfunction

   // Remove the bit at position idx, closing the gap.
   function automatic logic [TAG_MAX_W-1:0] tag_strip(input logic [TAG_MAX_W-1:0] tag,
                                                      input int                   idx);
      logic [TAG_MAX_W-1:0] low_mask;
      low_mask = (TAG_MAX_W'(1) << idx) - TAG_MAX_W'(1);
      return ((tag >> 1) & ~low_mask) | (tag & low_mask);
   endfunction

endpackage

// File: rtl/vx_tex_lsu_cache_arb_if.sv
// Request/response bundle between the two requesters, the arbiter and the dcache port.
// Per-source vectors pack source i at slice [i*W +: W] (bit/slice 1 = tex, 0 = lsu).
interface vx_tex_lsu_cache_arb_if
   import vx_tex_arb_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int WORD_SIZE    = 4,
   parameter int ADDR_WIDTH   = 30,
   parameter int TAG_IN_WIDTH = 8
);
   localparam int BEN_W  = NUM_LANES * WORD_SIZE;
   localparam int ADDR_W = NUM_LANES * ADDR_WIDTH;
   localparam int DATA_W = NUM_LANES * WORD_SIZE * 8;

   logic [NUM_SRC-1:0]              req_valid_in;
   logic [NUM_SRC-1:0]              req_rw_in;
   logic [NUM_SRC*NUM_LANES-1:0]    req_tmask_in;
   logic [NUM_SRC*BEN_W-1:0]        req_byteen_in;
   logic [NUM_SRC*ADDR_W-1:0]       req_addr_in;
   logic [NUM_SRC*DATA_W-1:0]       req_data_in;
   logic [NUM_SRC*TAG_IN_WIDTH-1:0] req_tag_in;
   logic [NUM_SRC-1:0]              req_ready_in;

   logic                            req_valid_out;
   logic                            req_rw_out;
   logic [NUM_LANES-1:0]            req_tmask_out;
   logic [BEN_W-1:0]                req_byteen_out;
   logic [ADDR_W-1:0]               req_addr_out;
   logic [DATA_W-1:0]               req_data_out;
   logic [TAG_IN_WIDTH:0]           req_tag_out;
   logic                            req_ready_out;

   logic                            rsp_valid_in;
   logic [NUM_LANES-1:0]            rsp_tmask_in;
   logic [DATA_W-1:0]               rsp_data_in;
   logic [TAG_IN_WIDTH:0]           rsp_tag_in;
   logic                            rsp_ready_in;

   logic [NUM_SRC-1:0]              rsp_valid_out;
   logic [NUM_SRC*NUM_LANES-1:0]    rsp_tmask_out;
   logic [NUM_SRC*DATA_W-1:0]       rsp_data_out;
   logic [NUM_SRC*TAG_IN_WIDTH-1:0] rsp_tag_out;
   logic [NUM_SRC-1:0]              rsp_ready_out;

   modport master (
      output req_valid_in, req_rw_in, req_tmask_in, req_byteen_in, req_addr_in, req_data_in,
             req_tag_in, req_ready_out, rsp_valid_in, rsp_tmask_in, rsp_data_in, rsp_tag_in,
             rsp_ready_out,
      input  req_ready_in, req_valid_out, req_rw_out, req_tmask_out, req_byteen_out,
             req_addr_out, req_data_out, req_tag_out, rsp_ready_in, rsp_valid_out,
             rsp_tmask_out, rsp_data_out, rsp_tag_out
   );

   modport slave (
      input  req_valid_in, req_rw_in, req_tmask_in, req_byteen_in, req_addr_in, req_data_in,
             req_tag_in, req_ready_out, rsp_valid_in, rsp_tmask_in, rsp_data_in, rsp_tag_in,
             rsp_ready_out,
      output req_ready_in, req_valid_out, req_rw_out, req_tmask_out, req_byteen_out,
             req_addr_out, req_data_out, req_tag_out, rsp_ready_in, rsp_valid_out,
             rsp_tmask_out, rsp_data_out, rsp_tag_out
   );

endinterface

// File: rtl/vx_tex_lsu_cache_arb_skid_buf2.sv
// vx_skid_buf2: generic 2-entry elastic buffer. in_ready depends only on occupancy,
// so the upstream handshake never sees the downstream ready combinationally.
module vx_skid_buf2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic [1:0]       count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next occupancy and slot contents; push+pop only happens at occupancy 1.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = in_data;
            else                 tail_d = in_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: head_d = in_data;
         default: ;
      endcase
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule

// File: rtl/vx_tex_lsu_cache_arb.sv
// Texture/LSU request arbiter and response router onto one dcache port.
// Optional macro TEX_LSU_ARB_PERF_EN adds saturating per-source stall counters.
module vx_tex_lsu_cache_arb
   import vx_tex_arb_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int WORD_SIZE    = 4,
   parameter int ADDR_WIDTH   = 30,
   parameter int TAG_IN_WIDTH = 8,
   parameter int TAG_SEL_IDX  = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   vx_tex_lsu_cache_arb_if.slave   bus
`ifdef TEX_LSU_ARB_PERF_EN
   ,
   output logic [31:0]             perf_tex_stall_o,
   output logic [31:0]             perf_lsu_stall_o
`endif
);
   localparam int MASK_W    = NUM_LANES;
   localparam int BEN_W     = NUM_LANES * WORD_SIZE;
   localparam int ADDR_W    = NUM_LANES * ADDR_WIDTH;
   localparam int DATA_W    = NUM_LANES * WORD_SIZE * 8;
   localparam int TAG_OUT_W = TAG_IN_WIDTH + 1;
   localparam int PAY_W     = 1 + MASK_W + BEN_W + ADDR_W + DATA_W + TAG_OUT_W;

   src_e               rr_ptr_q, rr_ptr_d;
   src_e               win_sel;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] req_ready;
   logic               buf_in_ready;
   logic               buf_push;
   logic [PAY_W-1:0]   src_payload [NUM_SRC];
   logic [PAY_W-1:0]   push_payload;
   logic [PAY_W-1:0]   buf_out_data;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign src_payload[g] = {bus.req_rw_in[g],
                               bus.req_tmask_in[g*MASK_W +: MASK_W],
                               bus.req_byteen_in[g*BEN_W +: BEN_W],
                               bus.req_addr_in[g*ADDR_W +: ADDR_W],
                               bus.req_data_in[g*DATA_W +: DATA_W],
                               TAG_OUT_W'(tag_insert(
                                  TAG_MAX_W'(bus.req_tag_in[g*TAG_IN_WIDTH +: TAG_IN_WIDTH]),
                                  1'(g), TAG_SEL_IDX))};
   end

   // Round-robin pick: the pointer source wins when valid, otherwise the other one.
   always_comb begin
      win_sel        = bus.req_valid_in[rr_ptr_q] ? rr_ptr_q : src_e'(~rr_ptr_q);
      grant          = '0;
      grant[win_sel] = bus.req_valid_in[win_sel];
      req_ready      = grant & {NUM_SRC{buf_in_ready & reset}};
      buf_push       = |req_ready;
      push_payload   = src_payload[win_sel];
      rr_ptr_d       = buf_push ? src_e'(~win_sel) : rr_ptr_q;
   end

   assign bus.req_ready_in = req_ready;

   // Round-robin pointer register; LSU has priority out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= SRC_LSU;
      else        rr_ptr_q <= rr_ptr_d;
   end

   vx_skid_buf2 #(.WIDTH(PAY_W)) u_req_buf (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (buf_push),
      .in_ready  (buf_in_ready),
      .in_data   (push_payload),
      .out_valid (bus.req_valid_out),
      .out_ready (bus.req_ready_out),
      .out_data  (buf_out_data)
   );

   assign {bus.req_rw_out, bus.req_tmask_out, bus.req_byteen_out,
           bus.req_addr_out, bus.req_data_out, bus.req_tag_out} = buf_out_data;

   logic                    rsp_valid_q, rsp_valid_d;
   src_e                    rsp_sel_q, rsp_sel_d;
   logic [MASK_W-1:0]       rsp_tmask_q, rsp_tmask_d;
   logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
   logic [TAG_IN_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
   logic                    rsp_fire_out;
   logic                    rsp_ready;

   // Single response slot: refills in the same cycle its owner drains it, so
   // a blocked owner holds up everything behind it (strict arrival order).
   always_comb begin
      rsp_fire_out = rsp_valid_q & bus.rsp_ready_out[rsp_sel_q];
      rsp_ready    = ~rsp_valid_q | rsp_fire_out;
      rsp_valid_d  = rsp_valid_q;
      rsp_sel_d    = rsp_sel_q;
      rsp_tmask_d  = rsp_tmask_q;
      rsp_data_d   = rsp_data_q;
      rsp_tag_d    = rsp_tag_q;
      if (bus.rsp_valid_in && rsp_ready) begin
         rsp_valid_d = 1'b1;
         rsp_sel_d   = src_e'(bus.rsp_tag_in[TAG_SEL_IDX]);
         rsp_tmask_d = bus.rsp_tmask_in;
         rsp_data_d  = bus.rsp_data_in;
         rsp_tag_d   = TAG_IN_WIDTH'(tag_strip(TAG_MAX_W'(bus.rsp_tag_in), TAG_SEL_IDX));
      end else if (rsp_fire_out) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Response register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_q <= 1'b0;
         rsp_sel_q   <= SRC_LSU;
         rsp_tmask_q <= '0;
         rsp_data_q  <= '0;
         rsp_tag_q   <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_sel_q   <= rsp_sel_d;
         rsp_tmask_q <= rsp_tmask_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   assign bus.rsp_ready_in  = rsp_ready;
   assign bus.rsp_valid_out = {rsp_valid_q & (rsp_sel_q == SRC_TEX),
                               rsp_valid_q & (rsp_sel_q == SRC_LSU)};
   // Payload is broadcast; only the slot whose valid is set is meaningful.
   assign bus.rsp_tmask_out = {NUM_SRC{rsp_tmask_q}};
   assign bus.rsp_data_out  = {NUM_SRC{rsp_data_q}};
   assign bus.rsp_tag_out   = {NUM_SRC{rsp_tag_q}};

`ifdef TEX_LSU_ARB_PERF_EN
   logic [31:0]        perf_tex_q, perf_tex_d;
   logic [31:0]        perf_lsu_q, perf_lsu_d;
   logic [NUM_SRC-1:0] stall;

   // Saturating stall counters: valid but not granted.
   always_comb begin
      stall      = bus.req_valid_in & ~req_ready;
      perf_tex_d = perf_tex_q;
      perf_lsu_d = perf_lsu_q;
      if (stall[SRC_TEX] && (perf_tex_q != '1)) perf_tex_d = perf_tex_q + 32'd1;
      if (stall[SRC_LSU] && (perf_lsu_q != '1)) perf_lsu_d = perf_lsu_q + 32'd1;
   end

   // Stall counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_tex_q <= '0;
         perf_lsu_q <= '0;
      end else begin
         perf_tex_q <= perf_tex_d;
         perf_lsu_q <= perf_lsu_d;
      end
   end

   assign perf_tex_stall_o = perf_tex_q;
   assign perf_lsu_stall_o = perf_lsu_q;
`endif

endmodule
